// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin arbiter sharing one Wishbone slave port
// among NM masters. Master 0 is the link bridge and wins first after reset.
// Optional watchdog enabled with `define WB_ARB_TIMEOUT_EN: it terminates a
// strobe the slave leaves unanswered for TIMEOUT cycles with an err pulse.
module wb_master_arbiter #(
  parameter int NM      = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [4*NM-1:0]   m_sel_i,
  input  logic [32*NM-1:0]  m_adr_i,
  input  logic [32*NM-1:0]  m_dat_i,
  input  logic [3*NM-1:0]   m_cti_i,
  input  logic [2*NM-1:0]   m_bte_i,
  output logic [31:0]       m_dat_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [31:0]       s_adr_o,
  output logic [31:0]       s_dat_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [NM-1:0]     gnt_o,
  output logic              busy_o
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;

  logic [IW-1:0] pick_hi;
  logic [IW-1:0] pick_lo;
  logic          found_hi;
  logic [IW-1:0] next_owner;
  logic          wd_fire;

  // Round-robin pick: lowest requester above the last grant, else lowest overall.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (m_cyc_i[i]) begin
        pick_lo = IW'(i);
        if (IW'(i) > last) begin
          pick_hi  = IW'(i);
          found_hi = 1'b1;
        end else begin
          found_hi = found_hi;
        end
      end else begin
        pick_lo = pick_lo;
      end
    end
    if (found_hi) begin
      next_owner = pick_hi;
    end else begin
      next_owner = pick_lo;
    end
  end

  // Ownership FSM: grant in idle, hold until the owner drops cyc.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= S_IDLE;
      owner <= '0;
      last  <= IW'(NM - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (|m_cyc_i) begin
            owner <= next_owner;
            last  <= next_owner;
            state <= S_OWN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_OWN: begin
          if (!m_cyc_i[owner]) begin
            state <= S_IDLE;
          end else begin
            state <= S_OWN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt;

  assign wd_fire = (state == S_OWN) && m_stb_i[owner] && !s_ack_i && !s_err_i
                   && (wd_cnt == WD_LAST);

  // Watchdog: counts unanswered strobe cycles; any response or pause restarts it.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wd_cnt <= 16'd0;
    end else if ((state != S_OWN) || s_ack_i || s_err_i || !m_stb_i[owner] || wd_fire) begin
      wd_cnt <= 16'd0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign m_dat_o = s_dat_i;
  assign busy_o  = (state == S_OWN);

  // Request/response routing: the owner's signals pass straight through while it owns the bus.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'd0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_cti_o = 3'd0;
    s_bte_o = 2'd0;
    gnt_o   = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state == S_OWN) begin
      s_cyc_o        = m_cyc_i[owner];
      s_stb_o        = m_stb_i[owner] & ~wd_fire;
      s_we_o         = m_we_i[owner];
      s_sel_o        = m_sel_i[4*owner +: 4];
      s_adr_o        = m_adr_i[32*owner +: 32];
      s_dat_o        = m_dat_i[32*owner +: 32];
      s_cti_o        = m_cti_i[3*owner +: 3];
      s_bte_o        = m_bte_i[2*owner +: 2];
      gnt_o[owner]   = 1'b1;
      m_ack_o[owner] = s_ack_i & m_stb_i[owner];
      m_err_o[owner] = (s_err_i & m_stb_i[owner]) | wd_fire;
    end else begin
      gnt_o = '0;
    end
  end

endmodule
